// File: rtl/bpu_pht_updater.sv
// bpu_pht_updater
// Update-side driver for a gshare pattern history table. It owns the speculative
// and architectural global history registers and tracks in-flight conditional
// branch predictions in an in-order FIFO.
//
// Fetch side: lookup_addr = pred_pc[PHT_WIDTH+1:2] ^ spec_ghr. Each accepted
// prediction {lookup_addr, pred_taken} is recorded in the FIFO, and the
// speculative history is shifted with the predicted direction.
// Resolve side: the oldest record is popped when its branch resolves. The PHT
// update port (branch_en/update_addr/taken) is driven one cycle later. A
// mispredict or a flush squashes all younger records and rebuilds the
// speculative history from the architectural one.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   pred_valid      a conditional branch is predicted this cycle
//   pred_pc         PC of that branch
//   pred_taken      PHT prediction returned for lookup_addr
//   pred_ready      FIFO not full (combinational)
//   lookup_addr     PHT index for pred_pc (combinational)
//   resolve_valid   oldest in-flight branch resolved
//   resolve_taken   actual direction of that branch
//   flush           non-branch pipeline redirect
//   branch_en       PHT update strobe (registered)
//   update_addr     PHT index to train (registered)
//   taken           direction to train (registered)
//   mispredict      one-cycle pulse when the resolved direction differs from the prediction
//   inflight        FIFO occupancy
module bpu_pht_updater #(
   parameter int PHT_WIDTH  = 6,
   parameter int PC_WIDTH   = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           pred_valid,
   input  logic [PC_WIDTH-1:0]            pred_pc,
   input  logic                           pred_taken,
   output logic                           pred_ready,
   output logic [PHT_WIDTH-1:0]           lookup_addr,
   input  logic                           resolve_valid,
   input  logic                           resolve_taken,
   input  logic                           flush,
   output logic                           branch_en,
   output logic [PHT_WIDTH-1:0]           update_addr,
   output logic                           taken,
   output logic                           mispredict,
   output logic [$clog2(FIFO_DEPTH):0]    inflight
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PHT_WIDTH-1:0] fifo_idx  [FIFO_DEPTH];
   logic                 fifo_pred [FIFO_DEPTH];
   logic [PTR_W-1:0]     head;
   logic [PTR_W-1:0]     tail;
   logic [CNT_W-1:0]     count;

   logic [PHT_WIDTH-1:0] spec_ghr;
   logic [PHT_WIDTH-1:0] arch_ghr;
   logic [PHT_WIDTH-1:0] arch_ghr_next;

   logic full;
   logic empty;
   logic do_pop;
   logic do_push;
   logic head_mispredict;
   logic clear_fifo;

   // Only the word-index bits of the PC feed the hash; the rest is folded here
   // so the unused bits are visibly accounted for.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{pred_pc[PC_WIDTH-1:PHT_WIDTH+2], pred_pc[1:0]};

   function automatic logic [PHT_WIDTH-1:0] ghr_shift(input logic [PHT_WIDTH-1:0] ghr,
                                                      input logic dir);
      return {ghr[PHT_WIDTH-2:0], dir};
   endfunction

   // Occupancy flags and the hashed lookup index seen by the fetch side.
   assign full        = (count == CNT_W'(FIFO_DEPTH));
   assign empty       = (count == '0);
   assign pred_ready  = !full;
   assign lookup_addr = pred_pc[PHT_WIDTH+1:2] ^ spec_ghr;
   assign inflight    = count;

   // Decide what happens this cycle. A pop only happens with something to pop.
   // A wrong head prediction or a flush wipes the FIFO, and any push in that
   // cycle belongs to the squashed path, so it is dropped. A full FIFO rejects
   // a push even if the head leaves in the same cycle, which keeps pred_ready
   // free of any dependence on the resolve inputs.
   always_comb begin
      do_pop          = resolve_valid && !empty;
      head_mispredict = do_pop && (resolve_taken != fifo_pred[head]);
      clear_fifo      = head_mispredict || flush;
      do_push         = pred_valid && !full && !clear_fifo;
      arch_ghr_next   = do_pop ? ghr_shift(arch_ghr, resolve_taken) : arch_ghr;
   end

   // Record storage has no reset. The pointers and count decide which slots are
   // live, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (do_push) begin
         fifo_idx[tail]  <= lookup_addr;
         fifo_pred[tail] <= pred_taken;
      end
   end

   // FIFO bookkeeping. Pointers wrap naturally because the depth is a power of
   // two. A clear returns everything to the empty state at once.
   always_ff @(posedge clk) begin
      if (rst || clear_fifo) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            tail <= tail + PTR_W'(1);
         end
         if (do_pop) begin
            head <= head + PTR_W'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Global history. The architectural copy advances only on resolved branches.
   // The speculative copy advances on every accepted prediction. After a
   // mispredict or a flush it restarts from the architectural history, which
   // already includes the branch resolving this cycle. That keeps the two copies
   // equal whenever nothing is in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         arch_ghr <= '0;
         spec_ghr <= '0;
      end else begin
         arch_ghr <= arch_ghr_next;
         if (clear_fifo) begin
            spec_ghr <= arch_ghr_next;
         end else if (do_push) begin
            spec_ghr <= ghr_shift(spec_ghr, pred_taken);
         end
      end
   end

   // PHT update port, registered one cycle after the pop. The strobe and the
   // mispredict pulse last exactly one cycle. Address and direction hold their
   // last trained values between strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         branch_en   <= 1'b0;
         mispredict  <= 1'b0;
         taken       <= 1'b0;
         update_addr <= '0;
      end else begin
         branch_en  <= do_pop;
         mispredict <= head_mispredict;
         if (do_pop) begin
            update_addr <= fifo_idx[head];
            taken       <= resolve_taken;
         end
      end
   end

endmodule
